link_control: RTL

//  Control FSM directly upstream of the game datapath: paces the game at a fixed frame rate,

---
 rtl/link_control.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/link_control.sv
// Frame-paced game controller: one command then one draw request per frame.
// Optional draw watchdog enabled by defining CTRL_DRAW_TIMEOUT_EN.
module link_control #(
    parameter int unsigned FRAME_CYCLES  = 833333,
    parameter int unsigned ATTACK_FRAMES = 8,
    parameter int unsigned DRAW_TIMEOUT  = 262143
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_attack,
    input  logic draw_done,
    output logic init,
    output logic idle,
    output logic attack,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic draw,
    output logic timeout_err
);

    localparam int unsigned FW = $clog2(FRAME_CYCLES);
    localparam int unsigned AW = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES) : 1;

    typedef enum logic [2:0] {
        S_RESET,
        S_INIT,
        S_DRAW,
        S_WAIT,
        S_CMD
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     btn_meta_q, btn_sync_q;  // {up, down, left, right, attack}
    logic [FW-1:0]  frame_q;
    logic           tick;
    logic           pend_q, pend_d;
    logic [AW-1:0]  atk_q, atk_d;
    logic           wd_fire;

    assign tick = (frame_q == FW'(FRAME_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_RESET;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            frame_q    <= '0;
            pend_q     <= 1'b0;
            atk_q      <= '0;
        end else begin
            state_q    <= state_d;
            btn_meta_q <= {btn_up, btn_down, btn_left, btn_right, btn_attack};
            btn_sync_q <= btn_meta_q;
            frame_q    <= tick ? '0 : frame_q + 1'b1;
            pend_q     <= pend_d;
            atk_q      <= atk_d;
        end
    end

`ifdef CTRL_DRAW_TIMEOUT_EN
    localparam int unsigned TW = (DRAW_TIMEOUT > 1) ? $clog2(DRAW_TIMEOUT) : 1;
    logic [TW-1:0] wd_q;

    always_ff @(posedge clock) begin
        if (reset || state_q != S_DRAW) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end

    assign wd_fire     = (state_q == S_DRAW) && !draw_done && (wd_q == TW'(DRAW_TIMEOUT - 1));
    assign timeout_err = wd_fire;
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        atk_d   = atk_q;
        init    = 1'b0;
        idle    = 1'b0;
        attack  = 1'b0;
        up      = 1'b0;
        down    = 1'b0;
        left    = 1'b0;
        right   = 1'b0;
        draw    = 1'b0;

        // Only one frame may be owed; extra ticks while busy are dropped.
        if (tick && state_q != S_WAIT) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_RESET: state_d = S_INIT;
            S_INIT: begin
                init    = 1'b1;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                draw = 1'b1;
                if (draw_done || wd_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tick || pend_q) begin
                    state_d = S_CMD;
                    pend_d  = 1'b0;
                end
            end
            S_CMD: begin
                state_d = S_DRAW;
                if (atk_q != '0) begin
                    attack = 1'b1;
                    atk_d  = atk_q - 1'b1;
                end else if (btn_sync_q[0]) begin
                    attack = 1'b1;
                    atk_d  = AW'(ATTACK_FRAMES - 1);
                end else if ((btn_sync_q[4] && btn_sync_q[3]) ||
                             (btn_sync_q[2] && btn_sync_q[1])) begin
                    idle = 1'b1;
                end else if (btn_sync_q[4]) begin
                    up = 1'b1;
                end else if (btn_sync_q[3]) begin
                    down = 1'b1;
                end else if (btn_sync_q[2]) begin
                    left = 1'b1;
                end else if (btn_sync_q[1]) begin
                    right = 1'b1;
                end else begin
                    idle = 1'b1;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

endmodule
